// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised single-clock first-word-fall-through FIFO with status and sticky error flags
module fifo_sync_param #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic [WIDTH-1:0]         DATA_IN,
  input  logic                     WR_EN,
  input  logic                     RD_EN,
  input  logic                     CLR,
  output logic [WIDTH-1:0]         DATA_OUT,
  output logic                     EMPTY,
  output logic                     FULL,
  output logic                     ALMOST_EMPTY,
  output logic                     ALMOST_FULL,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVERFLOW,
  output logic                     UNDERFLOW
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_last;
  logic             r_ovf;
  logic             r_udf;

  logic             w_empty;
  logic             w_full;
  logic             w_rd_ok;
  logic             w_wr_ok;

  // Status derived only from the registered occupancy count
  always_comb begin
    w_empty = (r_count == '0);
    w_full  = (r_count == CW'(DEPTH));
    // A full FIFO can still take a write when a pop frees the head slot on the same edge
    w_rd_ok = RD_EN && !w_empty;
    w_wr_ok = WR_EN && (!w_full || w_rd_ok);
  end

  // Storage array; contents need no reset since COUNT gates their visibility
  always_ff @(posedge CLK) begin
    if (!CLR && w_wr_ok) begin
      r_mem[r_wr_ptr] <= DATA_IN;
    end
  end

  // Pointers, occupancy and sticky error flags; CLR overrides any request in the same cycle
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else if (CLR) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      if (w_wr_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_rd_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_wr_ok && !w_rd_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_rd_ok && !w_wr_ok) begin
        r_count <= r_count - CW'(1);
      end
      if (WR_EN && !w_wr_ok) begin
        r_ovf <= 1'b1;
      end
      if (RD_EN && w_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  // Remember the most recently presented head so DATA_OUT holds steady once the FIFO empties
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_last <= '0;
    end else if (!w_empty) begin
      r_last <= r_mem[r_rd_ptr];
    end
  end

  // Output mapping; head entry falls through whenever data is present
  always_comb begin
    DATA_OUT     = w_empty ? r_last : r_mem[r_rd_ptr];
    EMPTY        = w_empty;
    FULL         = w_full;
    ALMOST_EMPTY = (r_count <= CW'(AE_THRESH));
    ALMOST_FULL  = (r_count >= CW'(AF_THRESH));
    COUNT        = r_count;
    OVERFLOW     = r_ovf;
    UNDERFLOW    = r_udf;
  end

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - randomized self-checking bench for fifo_sync_param against a queue model
module tb_fifo_sync_param;

  localparam int W = 8;
  localparam int D = 16;

  logic         CLK = 1'b0;
  logic         RST_N;
  logic [W-1:0] DATA_IN;
  logic         WR_EN;
  logic         RD_EN;
  logic         CLR;
  logic [W-1:0] DATA_OUT;
  logic         EMPTY;
  logic         FULL;
  logic         ALMOST_EMPTY;
  logic         ALMOST_FULL;
  logic [4:0]   COUNT;
  logic         OVERFLOW;
  logic         UNDERFLOW;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] q[$];
  logic         m_ovf;
  logic         m_udf;
  logic [W-1:0] m_last;

  fifo_sync_param #(.WIDTH(W), .DEPTH(D), .AF_THRESH(D-2), .AE_THRESH(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .DATA_IN(DATA_IN), .WR_EN(WR_EN), .RD_EN(RD_EN), .CLR(CLR),
    .DATA_OUT(DATA_OUT), .EMPTY(EMPTY), .FULL(FULL), .ALMOST_EMPTY(ALMOST_EMPTY),
    .ALMOST_FULL(ALMOST_FULL), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
  );

  always #5 CLK = ~CLK;

  function automatic logic [W-1:0] exp_head();
    return (q.size() != 0) ? q[0] : m_last;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ovf  = 1'b0;
    m_udf  = 1'b0;
    m_last = '0;
  endtask

  // One clock of stimulus; the queue model advances on the same edge
  task automatic step(input logic wr, input logic rd, input logic clr, input logic [W-1:0] din);
    bit do_rd;
    bit do_wr;
    @(negedge CLK);
    WR_EN = wr; RD_EN = rd; CLR = clr; DATA_IN = din;
    @(posedge CLK);
    if (q.size() != 0) m_last = q[0];
    if (clr) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      do_rd = rd && (q.size() != 0);
      do_wr = wr && ((q.size() < D) || do_rd);
      if (rd && q.size() == 0) m_udf = 1'b1;
      if (wr && !do_wr) m_ovf = 1'b1;
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(din);
    end
    #1;
    WR_EN = 1'b0; RD_EN = 1'b0; CLR = 1'b0;
  endtask

  task automatic test_reset();
    RST_N = 1'b0; WR_EN = 1'b0; RD_EN = 1'b0; CLR = 1'b0; DATA_IN = '0;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    checks++; if (EMPTY !== 1'b1)        begin failures++; $display("FAIL reset_empty got=%b exp=1", EMPTY); end
    checks++; if (ALMOST_EMPTY !== 1'b1) begin failures++; $display("FAIL reset_ae got=%b exp=1", ALMOST_EMPTY); end
    checks++; if (FULL !== 1'b0)         begin failures++; $display("FAIL reset_full got=%b exp=0", FULL); end
    checks++; if (ALMOST_FULL !== 1'b0)  begin failures++; $display("FAIL reset_af got=%b exp=0", ALMOST_FULL); end
    checks++; if (COUNT !== 5'd0)        begin failures++; $display("FAIL reset_count got=%0d exp=0", COUNT); end
    checks++; if (OVERFLOW !== 1'b0)     begin failures++; $display("FAIL reset_ovf got=%b exp=0", OVERFLOW); end
    checks++; if (UNDERFLOW !== 1'b0)    begin failures++; $display("FAIL reset_udf got=%b exp=0", UNDERFLOW); end
    checks++; if (DATA_OUT !== 8'h00)    begin failures++; $display("FAIL reset_dout got=%h exp=00", DATA_OUT); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= D; i++) begin
      step(1'b1, 1'b0, 1'b0, W'(i));
      checks++; if (COUNT !== 5'(i)) begin failures++; $display("FAIL fill_count got=%0d exp=%0d", COUNT, i); end
      checks++; if (ALMOST_FULL !== (i >= D-2)) begin failures++; $display("FAIL fill_af count=%0d got=%b exp=%b", i, ALMOST_FULL, (i >= D-2)); end
      checks++; if (ALMOST_EMPTY !== (i <= 2)) begin failures++; $display("FAIL fill_ae count=%0d got=%b exp=%b", i, ALMOST_EMPTY, (i <= 2)); end
      checks++; if (FULL !== (i == D)) begin failures++; $display("FAIL fill_full count=%0d got=%b exp=%b", i, FULL, (i == D)); end
    end
    for (int i = 1; i <= D; i++) begin
      checks++; if (DATA_OUT !== W'(i)) begin failures++; $display("FAIL drain_data got=%h exp=%h", DATA_OUT, W'(i)); end
      step(1'b0, 1'b1, 1'b0, '0);
      checks++; if (COUNT !== 5'(D - i)) begin failures++; $display("FAIL drain_count got=%0d exp=%0d", COUNT, D - i); end
    end
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL drain_empty got=%b exp=1", EMPTY); end
    checks++; if (DATA_OUT !== 8'h10) begin failures++; $display("FAIL drain_hold got=%h exp=10", DATA_OUT); end
  endtask

  task automatic test_overflow_underflow();
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, W'($urandom_range(0, 8'h7F)));
    step(1'b1, 1'b0, 1'b0, 8'hAA);
    checks++; if (COUNT !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", COUNT); end
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", OVERFLOW); end
    for (int i = 0; i < D; i++) begin
      checks++; if (DATA_OUT !== exp_head() || DATA_OUT === 8'hAA) begin failures++; $display("FAIL ovf_drain got=%h exp=%h", DATA_OUT, exp_head()); end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    checks++; if (UNDERFLOW !== 1'b0) begin failures++; $display("FAIL udf_early got=%b exp=0", UNDERFLOW); end
    step(1'b0, 1'b1, 1'b0, '0);
    checks++; if (UNDERFLOW !== 1'b1) begin failures++; $display("FAIL udf_flag got=%b exp=1", UNDERFLOW); end
    checks++; if (OVERFLOW !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", OVERFLOW); end
    checks++; if (COUNT !== 5'd0) begin failures++; $display("FAIL udf_count got=%0d exp=0", COUNT); end
    step(1'b0, 1'b0, 1'b1, '0);
    checks++; if (OVERFLOW !== m_ovf || UNDERFLOW !== m_udf) begin failures++; $display("FAIL clr_flags got=%b%b exp=%b%b", OVERFLOW, UNDERFLOW, m_ovf, m_udf); end
    checks++; if (COUNT !== 5'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", COUNT); end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < D; i++) step(1'b1, 1'b0, 1'b0, W'($urandom_range(0, 8'h7F)));
    step(1'b1, 1'b1, 1'b0, 8'h55);
    checks++; if (COUNT !== 5'd16) begin failures++; $display("FAIL simfull_count got=%0d exp=16", COUNT); end
    checks++; if (OVERFLOW !== 1'b0) begin failures++; $display("FAIL simfull_ovf got=%b exp=0", OVERFLOW); end
    checks++; if (DATA_OUT !== exp_head()) begin failures++; $display("FAIL simfull_head got=%h exp=%h", DATA_OUT, exp_head()); end
    for (int i = 0; i < D; i++) begin
      checks++; if (DATA_OUT !== exp_head()) begin failures++; $display("FAIL simfull_drain got=%h exp=%h", DATA_OUT, exp_head()); end
      if (i == D-1) begin
        checks++; if (DATA_OUT !== 8'h55) begin failures++; $display("FAIL simfull_last got=%h exp=55", DATA_OUT); end
      end
      step(1'b0, 1'b1, 1'b0, '0);
    end
    step(1'b1, 1'b1, 1'b0, 8'h3C);
    checks++; if (COUNT !== 5'd1) begin failures++; $display("FAIL simempty_count got=%0d exp=1", COUNT); end
    checks++; if (DATA_OUT !== 8'h3C) begin failures++; $display("FAIL simempty_data got=%h exp=3c", DATA_OUT); end
    checks++; if (UNDERFLOW !== 1'b1) begin failures++; $display("FAIL simempty_udf got=%b exp=1", UNDERFLOW); end
    checks++; if (EMPTY !== 1'b0) begin failures++; $display("FAIL simempty_empty got=%b exp=0", EMPTY); end
    step(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_wrap_random();
    int pops = 0;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, W'($urandom));
    for (int c = 0; c < 80; c++) begin
      logic wr;
      logic rd;
      wr = ($urandom_range(0, 3) != 0);
      rd = ($urandom_range(0, 3) != 0);
      if (q.size() <= 4)  rd = 1'b0;
      if (q.size() >= 12) wr = 1'b0;
      if (rd) pops++;
      step(wr, rd, 1'b0, W'($urandom));
      checks++; if (COUNT !== 5'(q.size())) begin failures++; $display("FAIL wrap_count cyc=%0d got=%0d exp=%0d", c, COUNT, q.size()); end
      checks++; if (DATA_OUT !== exp_head()) begin failures++; $display("FAIL wrap_data cyc=%0d got=%h exp=%h", c, DATA_OUT, exp_head()); end
    end
    checks++; if (pops <= 2*D) begin failures++; $display("FAIL wrap_coverage pops=%0d need>%0d", pops, 2*D); end
    step(1'b0, 1'b0, 1'b1, '0);
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0, W'($urandom_range(1, 255)));
    checks++; if (COUNT !== 5'd7) begin failures++; $display("FAIL arst_pre got=%0d exp=7", COUNT); end
    @(negedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    model_reset();
    checks++; if (COUNT !== 5'd0) begin failures++; $display("FAIL arst_count got=%0d exp=0", COUNT); end
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL arst_empty got=%b exp=1", EMPTY); end
    checks++; if (DATA_OUT !== 8'h00) begin failures++; $display("FAIL arst_dout got=%h exp=00", DATA_OUT); end
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_clr_write();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, W'($urandom));
    step(1'b1, 1'b0, 1'b1, 8'h77);
    checks++; if (COUNT !== 5'd0) begin failures++; $display("FAIL clrwr_count got=%0d exp=0", COUNT); end
    checks++; if (EMPTY !== 1'b1) begin failures++; $display("FAIL clrwr_empty got=%b exp=1", EMPTY); end
    step(1'b0, 1'b1, 1'b1, '0);
    checks++; if (UNDERFLOW !== 1'b0) begin failures++; $display("FAIL clrrd_udf got=%b exp=0", UNDERFLOW); end
    step(1'b1, 1'b0, 1'b0, 8'h12);
    checks++; if (DATA_OUT !== 8'h12) begin failures++; $display("FAIL clrwr_data got=%h exp=12", DATA_OUT); end
    checks++; if (COUNT !== 5'd1) begin failures++; $display("FAIL clrwr_next got=%0d exp=1", COUNT); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow_underflow();
    test_simultaneous();
    test_wrap_random();
    test_async_reset();
    test_clr_write();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
